// File: rtl/spi_regbank_sync_if.sv
// Pin and core-side bundle of the SPI register-bank subnode.
// The host/core side uses master and the subnode uses slave.
interface spi_regbank_sync_if #(
  parameter int NUM_REGS = 3,
  parameter int REG_W    = 128,
  parameter int NUM_S    = 5,
  parameter int S_W      = 64,
  parameter int MODE_W   = 3
);
  logic                      sck;
  logic                      csb;
  logic                      mosi;
  logic                      miso;
  logic [NUM_REGS*REG_W-1:0] regs_flat;
  logic [MODE_W-1:0]         operation_mode;
  logic                      wr_strobe;
  logic [6:0]                wr_addr;
  logic [NUM_S*S_W-1:0]      s_flat;
  logic                      core_busy;

  modport slave (
    input  sck, csb, mosi, s_flat, core_busy,
    output miso, regs_flat, operation_mode, wr_strobe, wr_addr
  );

  modport master (
    output sck, csb, mosi, s_flat, core_busy,
    input  miso, regs_flat, operation_mode, wr_strobe, wr_addr
  );
endinterface

// File: rtl/spi_regbank_sync.sv
// SPI subnode for the Ascon core, fully in the clk domain: oversampled SPI pins,
// atomic register commits, snapshot reads and a sticky status register.
module spi_regbank_sync #(
  parameter int NUM_REGS    = 3,
  parameter int REG_W       = 128,
  parameter int NUM_S       = 5,
  parameter int S_W         = 64,
  parameter int MODE_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_regbank_sync_if.slave bus
);
  localparam int RS_W  = (REG_W > S_W) ? REG_W : S_W;
  localparam int OUT_W = (RS_W > 8) ? RS_W : 8;
  localparam int CNT_W = $clog2(OUT_W) + 1;
  localparam logic [6:0] ADDR_MODE = 7'h10;
  localparam logic [6:0] ADDR_STAT = 7'h11;
  localparam logic [6:0] ADDR_S0   = 7'h20;

  typedef enum logic [1:0] {CMD, WDATA, RDATA, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   armed_q, armed_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [6:0]             cmd_q, cmd_d;
  logic [REG_W-1:0]       shadow_q, shadow_d;
  logic [OUT_W-1:0]       out_q, out_d;
  logic                   miso_q, miso_d;
  logic                   commit_q, commit_d;
  logic [REG_W-1:0]       regs_q [NUM_REGS];
  logic [REG_W-1:0]       regs_d [NUM_REGS];
  logic [MODE_W-1:0]      mode_q, mode_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [6:0]             wr_addr_q, wr_addr_d;
  logic [2:0]             status_q, status_d;

  logic [S_W-1:0]   s_word [NUM_S];
  logic             sck_s, csb_s, mosi_s, rise, fall;
  logic [7:0]       cmd_new;
  logic [6:0]       addr_new;
  logic             is_data, is_mode, is_stat, is_state, cmd_ok;
  logic [CNT_W-1:0] len_new, cnt_dec;
  logic [OUT_W-1:0] snap;
  logic [2:0]       status_set;
  logic             status_clr;

  for (genvar gi = 0; gi < NUM_S; gi++) begin : g_s_word
    assign s_word[gi] = bus.s_flat[gi*S_W +: S_W];
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_flat
    assign bus.regs_flat[gi*REG_W +: REG_W] = regs_q[gi];
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rise     = sck_s & ~sck_prev_q;
  assign fall     = ~sck_s & sck_prev_q;
  assign cmd_new  = {cmd_q, mosi_s};
  assign addr_new = cmd_new[6:0];
  assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  // Decode of the command completed by the current sample, and the read snapshot.
  always_comb begin : decode
    is_data  = (addr_new < 7'(NUM_REGS));
    is_mode  = (addr_new == ADDR_MODE);
    is_stat  = (addr_new == ADDR_STAT);
    is_state = (addr_new >= ADDR_S0) && (addr_new < 7'(32 + NUM_S));
    cmd_ok   = cmd_new[7] ? (is_data | is_mode | is_stat | is_state) : (is_data | is_mode);
    len_new  = '0;
    snap     = '0;
    if (is_data)  len_new = CNT_W'(REG_W);
    if (is_mode)  len_new = CNT_W'(MODE_W);
    if (is_stat)  len_new = CNT_W'(3);
    if (is_state) len_new = CNT_W'(S_W);
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_new == 7'(i)) snap[OUT_W-1 -: REG_W] = regs_q[i];
    if (is_mode) snap[OUT_W-1 -: MODE_W] = mode_q;
    if (is_stat) snap[OUT_W-1 -: 3] = status_q;
    for (int i = 0; i < NUM_S; i++)
      if (addr_new == 7'(32 + i)) snap[OUT_W-1 -: S_W] = s_word[i];
  end

  always_comb begin : next_state
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
    csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], bus.csb};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sck_prev_d  = sck_s;
    armed_d     = armed_q | csb_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    miso_d      = miso_q;
    commit_d    = 1'b0;
    regs_d      = regs_q;
    mode_d      = mode_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = '0;
    status_set  = '0;
    status_clr  = 1'b0;

    case (state_q)
      CMD: begin
        // Unarmed after reset until csb has been seen high, so a frame cut by reset is not resumed.
        if (rise && armed_q && !csb_s) begin
          cmd_d = cmd_new[6:0];
          cnt_d = cnt_dec;
          if (cnt_q == CNT_W'(1)) begin
            cnt_d = len_new;
            if (!cmd_ok) begin
              state_d       = DONE;
              status_set[1] = 1'b1;
            end else if (cmd_new[7]) begin
              state_d = RDATA;
              out_d   = snap;
            end else begin
              state_d = WDATA;
            end
          end
        end
      end
      WDATA: begin
        if (rise) begin
          shadow_d = {shadow_q[REG_W-2:0], mosi_s};
          cnt_d    = cnt_dec;
          if (cnt_q == CNT_W'(1)) begin
            state_d  = DONE;
            commit_d = 1'b1;
          end
        end
      end
      RDATA: begin
        if (fall) begin
          miso_d = out_q[OUT_W-1];
          out_d  = {out_q[OUT_W-2:0], 1'b0};
        end
        if (rise) begin
          cnt_d = cnt_dec;
          if (cnt_q == CNT_W'(1)) begin
            state_d    = DONE;
            miso_d     = 1'b1;
            status_clr = (cmd_q == ADDR_STAT);
          end
        end
      end
      DONE:    miso_d = 1'b1;
      default: state_d = CMD;
    endcase

    if (commit_q) begin
      if (cmd_q == ADDR_MODE) begin
        if (bus.core_busy) begin
          status_set[2] = 1'b1;
        end else begin
          mode_d      = shadow_q[MODE_W-1:0];
          wr_strobe_d = 1'b1;
          wr_addr_d   = ADDR_MODE;
        end
      end else begin
        for (int i = 0; i < NUM_REGS; i++)
          if (cmd_q == 7'(i)) regs_d[i] = shadow_q;
        wr_strobe_d = 1'b1;
        wr_addr_d   = cmd_q;
      end
    end

    if (csb_s) begin
      if (state_q == WDATA) status_set[0] = 1'b1;
      state_d = CMD;
      cnt_d   = CNT_W'(8);
      miso_d  = 1'b1;
    end

    status_d = (status_clr ? 3'b000 : status_q) | status_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CMD;
      sck_sync_q  <= '0;
      csb_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= CNT_W'(8);
      cmd_q       <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      miso_q      <= 1'b1;
      commit_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      mode_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      csb_sync_q  <= csb_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      miso_q      <= miso_d;
      commit_q    <= commit_d;
      regs_q      <= regs_d;
      mode_q      <= mode_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      status_q    <= status_d;
    end
  end

  assign bus.miso           = miso_q;
  assign bus.operation_mode = mode_q;
  assign bus.wr_strobe      = wr_strobe_q;
  assign bus.wr_addr        = wr_addr_q;
endmodule

// File: tb/tb_spi_regbank_sync.sv
// Directed bench for spi_regbank_sync: SPI frames bit-banged from tasks,
// expected values hand-computed per scenario.
module tb_spi_regbank_sync;
  localparam int NUM_REGS    = 3;
  localparam int REG_W       = 128;
  localparam int NUM_S       = 5;
  localparam int S_W         = 64;
  localparam int MODE_W      = 3;
  localparam int SYNC_STAGES = 2;
  localparam int CLK_P       = 10;
  localparam int HALF        = 80;

  localparam logic [127:0] REG0_VAL = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] REG2_VAL = 128'hA5A5_3C3C_0000_FFFF_8001_7FFE_1234_5678;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   strobe_cnt = 0;
  logic [6:0] last_addr = '0;

  spi_regbank_sync_if #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .NUM_S(NUM_S),
                        .S_W(S_W), .MODE_W(MODE_W)) bus();

  spi_regbank_sync #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .NUM_S(NUM_S), .S_W(S_W),
                     .MODE_W(MODE_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #(CLK_P/2) clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      strobe_cnt++;
      last_addr = bus.wr_addr;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0 bit: present mosi, host samples miso at the rising edge.
  task automatic spi_bit(input logic v, output logic b);
    bus.mosi = v;
    #(HALF);
    b = bus.miso;
    bus.sck = 1'b1;
    #(HALF);
    bus.sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input int nbits,
                           input logic [255:0] wdat, output logic [255:0] rdat);
    logic b;
    @(negedge clk);
    bus.csb = 1'b0;
    wait_clks(8);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], b);
    rdat = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_bit(wdat[i], b);
      rdat[i] = b;
    end
    wait_clks(8);
    bus.csb = 1'b1;
    wait_clks(12);
    $display("xfer cmd=%02h bits=%0d rx=%h", cmd, nbits, rdat);
  endtask

  task automatic test_reset();
    logic [255:0] r;
    rst = 1'b1;
    wait_clks(3);
    total++; if (bus.miso !== 1'b1) begin bad++; $display("FAIL reset_miso got=%b exp=1", bus.miso); end
    total++; if (bus.regs_flat !== '0) begin bad++; $display("FAIL reset_regs got=%h exp=0", bus.regs_flat); end
    total++; if (bus.operation_mode !== 3'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", bus.operation_mode); end
    total++; if (bus.wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", bus.wr_strobe); end
    total++; if (bus.wr_addr !== 7'd0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", bus.wr_addr); end
    rst = 1'b0;
    wait_clks(10);
    spi_frame(8'h91, 3, '0, r);
    total++; if (r[2:0] !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=000", r[2:0]); end
  endtask

  task automatic test_write_reg0();
    logic [255:0] r;
    int sc0;
    sc0 = strobe_cnt;
    spi_frame(8'h00, 128, {128'd0, REG0_VAL}, r);
    total++; if (bus.regs_flat[127:0] !== REG0_VAL) begin bad++; $display("FAIL wr_reg0 got=%h exp=%h", bus.regs_flat[127:0], REG0_VAL); end
    total++; if (bus.regs_flat[383:128] !== '0) begin bad++; $display("FAIL wr_reg0_others got=%h exp=0", bus.regs_flat[383:128]); end
    total++; if (strobe_cnt - sc0 !== 1) begin bad++; $display("FAIL wr_reg0_strobes got=%0d exp=1", strobe_cnt - sc0); end
    total++; if (last_addr !== 7'h00) begin bad++; $display("FAIL wr_reg0_addr got=%h exp=00", last_addr); end
    total++; if (bus.wr_addr !== 7'h00) begin bad++; $display("FAIL wr_addr_idle got=%h exp=00", bus.wr_addr); end
  endtask

  task automatic test_abort();
    logic [255:0] r;
    int sc0;
    sc0 = strobe_cnt;
    spi_frame(8'h01, 64, {192'd0, 64'hFFFF_0000_AAAA_5555}, r);
    total++; if (bus.regs_flat[255:128] !== '0) begin bad++; $display("FAIL abort_reg1 got=%h exp=0", bus.regs_flat[255:128]); end
    total++; if (strobe_cnt !== sc0) begin bad++; $display("FAIL abort_strobe got=%0d exp=%0d", strobe_cnt, sc0); end
    spi_frame(8'h91, 3, '0, r);
    total++; if (r[2:0] !== 3'b001) begin bad++; $display("FAIL abort_status got=%b exp=001", r[2:0]); end
    spi_frame(8'h91, 3, '0, r);
    total++; if (r[2:0] !== 3'b000) begin bad++; $display("FAIL status_cleared got=%b exp=000", r[2:0]); end
  endtask

  task automatic test_mode();
    logic [255:0] r;
    int sc0;
    sc0 = strobe_cnt;
    bus.core_busy = 1'b0;
    spi_frame(8'h10, 3, 256'd3, r);
    total++; if (bus.operation_mode !== 3'd3) begin bad++; $display("FAIL mode_write got=%0d exp=3", bus.operation_mode); end
    total++; if (last_addr !== 7'h10 || strobe_cnt - sc0 !== 1) begin bad++; $display("FAIL mode_strobe got=%h/%0d exp=10/1", last_addr, strobe_cnt - sc0); end
    bus.core_busy = 1'b1;
    spi_frame(8'h10, 3, 256'd1, r);
    bus.core_busy = 1'b0;
    total++; if (bus.operation_mode !== 3'd3) begin bad++; $display("FAIL mode_busy got=%0d exp=3", bus.operation_mode); end
    total++; if (strobe_cnt - sc0 !== 1) begin bad++; $display("FAIL mode_busy_strobe got=%0d exp=1", strobe_cnt - sc0); end
    spi_frame(8'h91, 3, '0, r);
    total++; if (r[2:0] !== 3'b100) begin bad++; $display("FAIL busy_status got=%b exp=100", r[2:0]); end
  endtask

  task automatic test_snapshot();
    logic [255:0] r;
    bus.s_flat[2*S_W +: S_W] = 64'hDEADBEEFCAFEF00D;
    fork
      spi_frame(8'hA2, 64, '0, r);
      begin
        #(HALF*2*40);
        bus.s_flat[2*S_W +: S_W] = 64'h0123456789ABCDEF;
      end
    join
    total++; if (r[63:0] !== 64'hDEADBEEFCAFEF00D) begin bad++; $display("FAIL snap_word2 got=%h exp=deadbeefcafef00d", r[63:0]); end
    bus.s_flat[4*S_W +: S_W] = 64'h5A5A0F0F12348001;
    spi_frame(8'hA4, 64, '0, r);
    total++; if (r[63:0] !== 64'h5A5A0F0F12348001) begin bad++; $display("FAIL snap_word4 got=%h exp=5a5a0f0f12348001", r[63:0]); end
  endtask

  task automatic test_bad_cmd();
    logic [255:0] r;
    int sc0;
    sc0 = strobe_cnt;
    spi_frame(8'h20, 64, {192'd0, 64'h0F0F_0F0F_0F0F_0F0F}, r);
    total++; if (r[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL bad_cmd_miso got=%h exp=ffffffffffffffff", r[63:0]); end
    total++; if (strobe_cnt !== sc0) begin bad++; $display("FAIL bad_cmd_strobe got=%0d exp=%0d", strobe_cnt, sc0); end
    total++; if (bus.regs_flat[127:0] !== REG0_VAL || bus.operation_mode !== 3'd3) begin bad++; $display("FAIL bad_cmd_state got=%h/%0d exp=%h/3", bus.regs_flat[127:0], bus.operation_mode, REG0_VAL); end
    spi_frame(8'h91, 3, '0, r);
    total++; if (r[2:0] !== 3'b010) begin bad++; $display("FAIL bad_cmd_status got=%b exp=010", r[2:0]); end
  endtask

  task automatic test_read_140();
    logic [255:0] r;
    spi_frame(8'h80, 140, '0, r);
    total++; if (r[139:12] !== REG0_VAL) begin bad++; $display("FAIL rd140_data got=%h exp=%h", r[139:12], REG0_VAL); end
    total++; if (r[11:0] !== 12'hFFF) begin bad++; $display("FAIL rd140_tail got=%h exp=fff", r[11:0]); end
    spi_frame(8'h90, 3, '0, r);
    total++; if (r[2:0] !== 3'b011) begin bad++; $display("FAIL next_cmd_mode got=%b exp=011", r[2:0]); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] r;
    int sc0;
    sc0 = strobe_cnt;
    spi_frame(8'h02, 128, {128'd0, REG2_VAL}, r);
    total++; if (bus.regs_flat[383:256] !== REG2_VAL) begin bad++; $display("FAIL b2b_reg2 got=%h exp=%h", bus.regs_flat[383:256], REG2_VAL); end
    total++; if (last_addr !== 7'h02 || strobe_cnt - sc0 !== 1) begin bad++; $display("FAIL b2b_strobe got=%h/%0d exp=02/1", last_addr, strobe_cnt - sc0); end
    spi_frame(8'h82, 128, '0, r);
    total++; if (r[127:0] !== REG2_VAL) begin bad++; $display("FAIL b2b_read got=%h exp=%h", r[127:0], REG2_VAL); end
    total++; if (bus.regs_flat[255:0] !== {128'd0, REG0_VAL}) begin bad++; $display("FAIL b2b_others got=%h exp=%h", bus.regs_flat[255:0], {128'd0, REG0_VAL}); end
  endtask

  task automatic test_rst_mid();
    logic [255:0] r;
    logic [7:0]   c;
    logic         b;
    int           sc0;
    @(negedge clk);
    bus.csb = 1'b0;
    wait_clks(8);
    c = 8'h01;
    for (int i = 7; i >= 0; i--) spi_bit(c[i], b);
    for (int i = 0; i < 20; i++) spi_bit(1'b1, b);
    rst = 1'b1;
    #2;
    total++; if (bus.regs_flat !== '0 || bus.operation_mode !== 3'd0) begin bad++; $display("FAIL rst_mid_clear got=%h/%0d exp=0/0", bus.regs_flat, bus.operation_mode); end
    wait_clks(2);
    rst = 1'b0;
    sc0 = strobe_cnt;
    c = 8'h10;
    for (int i = 7; i >= 0; i--) spi_bit(c[i], b);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
    wait_clks(8);
    bus.csb = 1'b1;
    wait_clks(12);
    $display("xfer cmd=10 bits=3 after mid-frame reset, csb held low");
    total++; if (bus.operation_mode !== 3'd0) begin bad++; $display("FAIL rst_unarmed_mode got=%0d exp=0", bus.operation_mode); end
    total++; if (strobe_cnt !== sc0) begin bad++; $display("FAIL rst_unarmed_strobe got=%0d exp=%0d", strobe_cnt, sc0); end
    total++; if (bus.miso !== 1'b1) begin bad++; $display("FAIL rst_miso got=%b exp=1", bus.miso); end
    spi_frame(8'h80, 128, '0, r);
    total++; if (r[127:0] !== '0) begin bad++; $display("FAIL rst_reg0_read got=%h exp=0", r[127:0]); end
  endtask

  initial begin
    bus.sck       = 1'b0;
    bus.csb       = 1'b1;
    bus.mosi      = 1'b0;
    bus.s_flat    = '0;
    bus.core_busy = 1'b0;
    test_reset();
    test_write_reg0();
    test_abort();
    test_mode();
    test_snapshot();
    test_bad_cmd();
    test_read_140();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
